// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//   Independent safety monitor for a two-channel traffic signal controller.
//   Samples the six lamp drives every cycle and compares each new sample with
//   the previous one. It latches the first fault it sees (conflict, invalid
//   lamp pattern, illegal sequence, short yellow, watchdog) and requests
//   flash mode until software clears it.
//
// Parameters
//   MIN_YLW    minimum consecutive sampled cycles a yellow must stay lit
//   WDOG       maximum consecutive cycles with no decoded lamp change
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   grn1/ylw1/red1      channel-1 lamp drives
//   grn2/ylw2/red2      channel-2 lamp drives
//   fault_clr           single-cycle request to clear the latched fault
//   fault               latched fault indication
//   fault_code[2:0]     cause of the first fault (1..5), 0 when clear
//   flash_req           flash-mode request, equal to fault
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int unsigned MIN_YLW = 3,
    parameter int unsigned WDOG    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grn1,
    input  logic       ylw1,
    input  logic       red1,
    input  logic       grn2,
    input  logic       ylw2,
    input  logic       red2,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_req
);

    localparam int unsigned YW = $clog2(MIN_YLW + 1);
    localparam int unsigned WW = $clog2(WDOG + 1);

    typedef enum logic [1:0] {
        ST_G,
        ST_Y,
        ST_R,
        ST_INV
    } lamp_e;

    // Exactly one lamp lit decodes to a state; anything else is INVALID.
    function automatic lamp_e f_decode(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return ST_G;
            3'b010:  return ST_Y;
            3'b001:  return ST_R;
            default: return ST_INV;
        endcase
    endfunction

    function automatic logic f_legal(input lamp_e p, input lamp_e c);
        return (p == c) ||
               (p == ST_G && c == ST_Y) ||
               (p == ST_Y && c == ST_R) ||
               (p == ST_R && c == ST_G);
    endfunction

    // Sample stage: {grn1, ylw1, red1, grn2, ylw2, red2}
    logic [5:0]    r_samp;
    lamp_e         r_prev1;
    lamp_e         r_prev2;
    logic [YW-1:0] r_ycnt1;
    logic [YW-1:0] r_ycnt2;
    logic [WW-1:0] r_wd;
    logic          r_started;
    logic          r_armed;
    logic          r_fault;
    logic [2:0]    r_code;

    lamp_e         w_cur1;
    lamp_e         w_cur2;
    logic          w_conflict;
    logic          w_lamp;
    logic          w_seq;
    logic          w_short;
    logic          w_wdog;
    logic          w_same;
    logic [WW-1:0] w_wd_nxt;
    logic [YW-1:0] w_ycnt1_nxt;
    logic [YW-1:0] w_ycnt2_nxt;
    logic [2:0]    w_code;
    logic          w_cause;
    logic          w_clr;

    assign w_cur1 = f_decode(r_samp[5], r_samp[4], r_samp[3]);
    assign w_cur2 = f_decode(r_samp[2], r_samp[1], r_samp[0]);

    always_comb begin
        w_conflict = (w_cur1 == ST_G || w_cur1 == ST_Y) &&
                     (w_cur2 == ST_G || w_cur2 == ST_Y);
        w_lamp     = (w_cur1 == ST_INV) || (w_cur2 == ST_INV);
        w_seq      = r_armed && (!f_legal(r_prev1, w_cur1) || !f_legal(r_prev2, w_cur2));
        w_short    = r_armed &&
                     ((r_prev1 == ST_Y && w_cur1 == ST_R && r_ycnt1 < YW'(MIN_YLW)) ||
                      (r_prev2 == ST_Y && w_cur2 == ST_R && r_ycnt2 < YW'(MIN_YLW)));

        w_same     = (w_cur1 == r_prev1) && (w_cur2 == r_prev2);
        if (!w_same)
            w_wd_nxt = '0;
        else if (r_wd == WW'(WDOG))
            w_wd_nxt = r_wd;
        else
            w_wd_nxt = r_wd + 1'b1;
        w_wdog     = (w_wd_nxt == WW'(WDOG));

        // Counts start at 1 on the first Y because a non-Y sample always zeroes them.
        w_ycnt1_nxt = '0;
        if (w_cur1 == ST_Y)
            w_ycnt1_nxt = (r_ycnt1 == YW'(MIN_YLW)) ? r_ycnt1 : r_ycnt1 + 1'b1;
        w_ycnt2_nxt = '0;
        if (w_cur2 == ST_Y)
            w_ycnt2_nxt = (r_ycnt2 == YW'(MIN_YLW)) ? r_ycnt2 : r_ycnt2 + 1'b1;

        // Lowest code wins when several causes coincide.
        if (w_conflict)   w_code = 3'd1;
        else if (w_lamp)  w_code = 3'd2;
        else if (w_seq)   w_code = 3'd3;
        else if (w_short) w_code = 3'd4;
        else if (w_wdog)  w_code = 3'd5;
        else              w_code = 3'd0;

        w_cause = (w_code != 3'd0);
        // A clear only takes effect when nothing is firing in the same cycle.
        w_clr   = fault_clr && !w_cause;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp    <= 6'b001_001;
            r_prev1   <= ST_R;
            r_prev2   <= ST_R;
            r_ycnt1   <= '0;
            r_ycnt2   <= '0;
            r_wd      <= '0;
            r_started <= 1'b0;
            r_armed   <= 1'b0;
            r_fault   <= 1'b0;
            r_code    <= '0;
        end else begin
            r_samp    <= {grn1, ylw1, red1, grn2, ylw2, red2};
            r_prev1   <= w_cur1;
            r_prev2   <= w_cur2;
            r_started <= 1'b1;
            if (w_clr) begin
                r_ycnt1 <= '0;
                r_ycnt2 <= '0;
                r_wd    <= '0;
                r_armed <= 1'b0;
            end else begin
                r_ycnt1 <= w_ycnt1_nxt;
                r_ycnt2 <= w_ycnt2_nxt;
                r_wd    <= w_wd_nxt;
                // Arms one edge after the first real sample, so the first
                // sample is never judged against the reset/pre-clear state.
                r_armed <= r_started;
            end
            if (w_cause) begin
                r_fault <= 1'b1;
                if (!r_fault || fault_clr)
                    r_code <= w_code;
            end else if (fault_clr) begin
                r_fault <= 1'b0;
                r_code  <= '0;
            end
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign flash_req  = r_fault;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

    localparam logic [5:0] RR = 6'b001_001;
    localparam logic [5:0] GR = 6'b100_001;
    localparam logic [5:0] YR = 6'b010_001;
    localparam logic [5:0] RG = 6'b001_100;
    localparam logic [5:0] RY = 6'b001_010;
    localparam logic [5:0] GG = 6'b100_100;
    localparam logic [5:0] IG = 6'b011_100;  // ch1 red+yellow (invalid), ch2 green

    localparam int MIN = 3;
    localparam int SG = 0, SY = 1, SR = 2, SI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic grn1, ylw1, red1, grn2, ylw2, red2, fault_clr;
    logic fault_a, flash_a, fault_b, flash_b;
    logic [2:0] code_a, code_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(.MIN_YLW(3), .WDOG(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .grn1(grn1), .ylw1(ylw1), .red1(red1),
        .grn2(grn2), .ylw2(ylw2), .red2(red2),
        .fault_clr(fault_clr),
        .fault(fault_a), .fault_code(code_a), .flash_req(flash_a)
    );

    traffic_conflict_monitor #(.MIN_YLW(3), .WDOG(255)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .grn1(grn1), .ylw1(ylw1), .red1(red1),
        .grn2(grn2), .ylw2(ylw2), .red2(red2),
        .fault_clr(fault_clr),
        .fault(fault_b), .fault_code(code_b), .flash_req(flash_b)
    );

    // ---------------- reference model (one per instance) ----------------
    int         wlim [2] = '{8, 255};
    logic [5:0] msamp [2];
    int         mprev [2][2];
    int         mylen [2][2];   // unsaturated run length of Y samples
    int         mstill [2];     // unsaturated cycles with no decoded change
    int         medges [2];     // edges since reset / effective clear
    logic       mf [2];
    int         mc [2];

    function automatic int dec(input logic [2:0] v);
        case (v)
            3'b100:  return SG;
            3'b010:  return SY;
            3'b001:  return SR;
            default: return SI;
        endcase
    endfunction

    function automatic bit ok_step(input int p, input int c);
        return (p == c) || (p == SG && c == SY) || (p == SY && c == SR) || (p == SR && c == SG);
    endfunction

    function automatic void model_reset(input int k);
        msamp[k] = RR;
        mprev[k][0] = SR; mprev[k][1] = SR;
        mylen[k][0] = 0;  mylen[k][1] = 0;
        mstill[k] = 0; medges[k] = 0;
        mf[k] = 1'b0; mc[k] = 0;
    endfunction

    function automatic void model_step(input int k, input logic [5:0] lamps, input logic clr);
        int c [2];
        int cause;
        bit armed, eclr;
        logic [5:0] s;
        s = msamp[k];
        c[0] = dec(s[5:3]);
        c[1] = dec(s[2:0]);
        armed = (medges[k] >= 2);
        mstill[k] = (c[0] == mprev[k][0] && c[1] == mprev[k][1]) ? mstill[k] + 1 : 0;
        cause = 0;
        if ((c[0] == SG || c[0] == SY) && (c[1] == SG || c[1] == SY)) cause = 1;
        else if (c[0] == SI || c[1] == SI) cause = 2;
        else if (armed && (!ok_step(mprev[k][0], c[0]) || !ok_step(mprev[k][1], c[1]))) cause = 3;
        else if (armed && ((mprev[k][0] == SY && c[0] == SR && mylen[k][0] < MIN) ||
                           (mprev[k][1] == SY && c[1] == SR && mylen[k][1] < MIN))) cause = 4;
        else if (mstill[k] >= wlim[k]) cause = 5;
        if (cause != 0) begin
            if (!mf[k] || clr) mc[k] = cause;
            mf[k] = 1'b1;
        end else if (clr) begin
            mf[k] = 1'b0;
            mc[k] = 0;
        end
        eclr = clr && (cause == 0);
        for (int ch = 0; ch < 2; ch++)
            mylen[k][ch] = (c[ch] == SY && !eclr) ? mylen[k][ch] + 1 : 0;
        if (eclr) begin
            mstill[k] = 0;
            medges[k] = 1;
        end else begin
            medges[k] = medges[k] + 1;
        end
        mprev[k][0] = c[0];
        mprev[k][1] = c[1];
        msamp[k] = lamps;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, {grn1, ylw1, red1, grn2, ylw2, red2}, fault_clr);
            model_step(1, {grn1, ylw1, red1, grn2, ylw2, red2}, fault_clr);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_fault_a", int'(fault_a), int'(mf[0]));
        chk("model_code_a",  int'(code_a),  mc[0]);
        chk("model_flash_a", int'(flash_a), int'(mf[0]));
        chk("model_fault_b", int'(fault_b), int'(mf[1]));
        chk("model_code_b",  int'(code_b),  mc[1]);
        chk("model_flash_b", int'(flash_b), int'(mf[1]));
    endtask

    task automatic step(input logic [5:0] l, input logic c);
        {grn1, ylw1, red1, grn2, ylw2, red2} = l;
        fault_clr = c;
        @(posedge clk);
        @(negedge clk);
        chk_model();
    endtask

    task automatic hold(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0);
    endtask

    // ---------------- directed vectors (dut_a: MIN_YLW=3, WDOG=8) ----------------
    typedef struct {
        logic [5:0] lamps;
        logic       clr;
        logic       exp_f;
        logic [2:0] exp_c;
    } vec_t;

    vec_t tbl [29];

    initial begin
        logic [5:0] cur;
        tbl[0]  = '{RR, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{GR, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{YR, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{YR, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{RR, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{RR, 1'b0, 1'b1, 3'd4};  // yellow held only 2 samples
        tbl[6]  = '{GG, 1'b0, 1'b1, 3'd4};
        tbl[7]  = '{GG, 1'b1, 1'b1, 3'd1};  // conflict beats the clear, new code
        tbl[8]  = '{GR, 1'b1, 1'b1, 3'd1};
        tbl[9]  = '{GR, 1'b0, 1'b1, 3'd1};  // seq fault ignored: code frozen
        tbl[10] = '{GR, 1'b1, 1'b0, 3'd0};  // clean clear
        tbl[11] = '{RR, 1'b0, 1'b0, 3'd0};
        tbl[12] = '{RR, 1'b0, 1'b1, 3'd3};  // G->R skip once re-armed
        tbl[13] = '{IG, 1'b0, 1'b1, 3'd3};
        tbl[14] = '{RR, 1'b1, 1'b1, 3'd2};  // invalid lamps beat the clear
        tbl[15] = '{RR, 1'b1, 1'b1, 3'd3};
        tbl[16] = '{RR, 1'b1, 1'b0, 3'd0};
        for (int i = 17; i < 24; i++) tbl[i] = '{RR, 1'b0, 1'b0, 3'd0};
        tbl[24] = '{RR, 1'b0, 1'b1, 3'd5};  // 8 unchanged cycles
        tbl[25] = '{GR, 1'b0, 1'b1, 3'd5};
        tbl[26] = '{YR, 1'b1, 1'b0, 3'd0};
        tbl[27] = '{GG, 1'b0, 1'b0, 3'd0};
        tbl[28] = '{RR, 1'b0, 1'b1, 3'd1};  // conflict outranks Y->G sequence

        rst_n = 1'b0;
        {grn1, ylw1, red1, grn2, ylw2, red2} = RR;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fault_a", int'(fault_a), 0);
        chk("rst_code_a",  int'(code_a),  0);
        chk("rst_flash_a", int'(flash_a), 0);
        chk("rst_fault_b", int'(fault_b), 0);
        chk("rst_code_b",  int'(code_b),  0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].lamps, tbl[i].clr);
            chk($sformatf("tbl%0d_fault", i), int'(fault_a), int'(tbl[i].exp_f));
            chk($sformatf("tbl%0d_code", i),  int'(code_a),  int'(tbl[i].exp_c));
            chk($sformatf("tbl%0d_flash", i), int'(flash_a), int'(tbl[i].exp_f));
        end

        // Reset asserted between edges must clear the latched fault at once.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fault", int'(fault_a), 0);
        chk("async_rst_code",  int'(code_a),  0);
        chk("async_rst_flash", int'(flash_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full legal cycle on both channels; dut_b has a long watchdog.
        hold(RR, 2);
        hold(GR, 10);
        hold(YR, 3);
        hold(RR, 1);
        hold(RG, 10);
        hold(RY, 3);
        hold(RR, 3);
        chk("legal_fault_b", int'(fault_b), 0);
        chk("legal_code_b",  int'(code_b),  0);

        // Randomized traffic with holds, invalid patterns and clears.
        cur = RR;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0) begin
                logic [2:0] c1, c2;
                c1 = 3'b001 << $urandom_range(2);
                c2 = 3'b001 << $urandom_range(2);
                if ($urandom_range(15) == 0) c1 = 3'($urandom);
                if ($urandom_range(15) == 0) c2 = 3'($urandom);
                if ($urandom_range(1) == 0) c2 = 3'b001;
                cur = {c1, c2};
            end
            step(cur, ($urandom_range(7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
